// File: rtl/timer_share_sched_pkg.sv
// Shared definitions for timer_share_sched.
//   - FSM state encodings (4-bit, also exported on the top-level debug port)
//   - interval-timer slave register addresses and control words
//   - period_of(): converts a requested delay in clk ticks into the timer period value
package timer_share_sched_pkg;

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_STOP       = 4'd1;
    localparam logic [3:0] ST_WR_PL      = 4'd2;
    localparam logic [3:0] ST_WR_PH      = 4'd3;
    localparam logic [3:0] ST_CLR        = 4'd4;
    localparam logic [3:0] ST_START      = 4'd5;
    localparam logic [3:0] ST_WAIT       = 4'd6;
    localparam logic [3:0] ST_ACK        = 4'd7;
    localparam logic [3:0] ST_ABORT_STOP = 4'd8;
    localparam logic [3:0] ST_ABORT_CLR  = 4'd9;

    localparam logic [2:0] TMR_STATUS  = 3'd0;
    localparam logic [2:0] TMR_CONTROL = 3'd1;
    localparam logic [2:0] TMR_PERIODL = 3'd2;
    localparam logic [2:0] TMR_PERIODH = 3'd3;

    localparam logic [15:0] CTRL_STOP      = 16'h0008;
    localparam logic [15:0] CTRL_START_ITO = 16'h0005;

    // The timer counts period..0 inclusive, so period = ticks-1. A period of 0
    // would fire a spurious timeout on reload, so tiny delays clamp to period 1.
    function automatic logic [31:0] period_of(input logic [31:0] ticks);
        return (ticks < 32'd2) ? 32'd1 : (ticks - 32'd1);
    endfunction

endpackage

// File: rtl/timer_share_sched_rr_arbiter.sv
// Round-robin arbiter (combinational).
//   req   : request vector
//   ptr   : index where the search starts (wraps upward)
//   grant : one-hot winner
//   idx   : encoded winner index
//   found : at least one request is present
module timer_share_sched_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [2:0]         idx,
    output logic               found
);

    logic [7:0] req_pad;
    logic [3:0] slot;

    assign req_pad = 8'(req);

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        slot  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // ptr + i, wrapped into 0..NUM_REQ-1 without a modulo operator
            slot = {1'b0, ptr} + 4'(i);
            if (slot >= 4'(NUM_REQ)) slot = slot - 4'(NUM_REQ);
            if (!found && req_pad[slot[2:0]]) begin
                found = 1'b1;
                idx   = slot[2:0];
            end
        end
        if (found) grant = NUM_REQ'(1) << idx;
    end

endmodule

// File: rtl/timer_share_sched.sv
// Shares one Avalon-MM interval timer among NUM_REQ requesters.
// A requester holds req[i] high with its delay on req_ticks slice i; the block
// grants round-robin, programs the timer for a one-shot timeout, waits for
// tmr_irq, clears it and pulses done[i]. Dropping req[i] while owned aborts.
//
// Ports:
//   clk, reset_n    : clock, asynchronous active-low reset
//   req, req_ticks  : level requests and packed per-requester delays
//   done            : one-cycle completion pulse to the owner
//   busy, owner     : activity flag and current owner index
//   tmr_*           : timer slave write port, tmr_irq from the timer
//   state           : current FSM state (debug)
//
// Bus protocol: a write is a single cycle with tmr_chipselect=1 and
// tmr_write_n=0, address and data valid in that same cycle; the slave is
// zero-wait so no handshake is needed and no reads are ever issued. Every
// bus output is registered, so the write belonging to state X is on the bus
// during the cycle the FSM sits in X.
import timer_share_sched_pkg::*;

module timer_share_sched #(
    parameter int NUM_REQ = 4,
    parameter int TICK_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*TICK_W-1:0] req_ticks,
    output logic [NUM_REQ-1:0]        done,
    output logic                      busy,
    output logic [2:0]                owner,
    output logic [2:0]                tmr_address,
    output logic                      tmr_chipselect,
    output logic                      tmr_write_n,
    output logic [15:0]               tmr_writedata,
    input  logic                      tmr_irq,
    output logic [3:0]                state
);

    logic [2:0]         ptr;
    logic [TICK_W-1:0]  delay;
    logic [NUM_REQ-1:0] owner_oh;
    logic [NUM_REQ-1:0] arb_grant;
    logic [2:0]         arb_idx;
    logic               arb_found;
    logic [TICK_W-1:0]  sel_ticks;
    logic [31:0]        period;
    logic               cancel;

    logic [3:0]         state_n;
    logic               wr;
    logic [2:0]         addr_n;
    logic [15:0]        data_n;
    logic [NUM_REQ-1:0] done_n;

    timer_share_sched_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .found (arb_found)
    );

    assign sel_ticks = req_ticks[int'(arb_idx)*TICK_W +: TICK_W];
    assign period    = period_of(32'(delay));
    // The owner withdrew its request: abort after the in-flight write.
    assign cancel    = ~|(req & owner_oh);

    always_comb begin
        state_n = state;
        wr      = 1'b0;
        addr_n  = TMR_STATUS;
        data_n  = 16'h0000;
        done_n  = '0;
        case (state)
            ST_IDLE: if (arb_found) begin
                state_n = ST_STOP;
                wr = 1'b1; addr_n = TMR_CONTROL; data_n = CTRL_STOP;
            end
            ST_STOP, ST_WR_PL, ST_WR_PH, ST_CLR, ST_START, ST_WAIT: begin
                if (cancel) begin
                    state_n = ST_ABORT_STOP;
                    wr = 1'b1; addr_n = TMR_CONTROL; data_n = CTRL_STOP;
                end else begin
                    case (state)
                        ST_STOP: begin
                            state_n = ST_WR_PL;
                            wr = 1'b1; addr_n = TMR_PERIODL; data_n = period[15:0];
                        end
                        ST_WR_PL: begin
                            state_n = ST_WR_PH;
                            wr = 1'b1; addr_n = TMR_PERIODH; data_n = period[31:16];
                        end
                        ST_WR_PH: begin
                            state_n = ST_CLR;
                            wr = 1'b1; addr_n = TMR_STATUS; data_n = 16'h0000;
                        end
                        ST_CLR: begin
                            state_n = ST_START;
                            wr = 1'b1; addr_n = TMR_CONTROL; data_n = CTRL_START_ITO;
                        end
                        ST_START: state_n = ST_WAIT;
                        default: if (tmr_irq) begin
                            state_n = ST_ACK;
                            wr = 1'b1; addr_n = TMR_STATUS; data_n = 16'h0000;
                            done_n = owner_oh;
                        end
                    endcase
                end
            end
            ST_ACK: state_n = ST_IDLE;
            ST_ABORT_STOP: begin
                state_n = ST_ABORT_CLR;
                wr = 1'b1; addr_n = TMR_STATUS; data_n = 16'h0000;
            end
            ST_ABORT_CLR: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            ptr            <= 3'd0;
            owner          <= 3'd0;
            owner_oh       <= '0;
            delay          <= '0;
            done           <= '0;
            busy           <= 1'b0;
            tmr_chipselect <= 1'b0;
            tmr_write_n    <= 1'b1;
            tmr_address    <= 3'd0;
            tmr_writedata  <= 16'h0000;
        end else begin
            state          <= state_n;
            busy           <= (state_n != ST_IDLE);
            done           <= done_n;
            tmr_chipselect <= wr;
            tmr_write_n    <= ~wr;
            tmr_address    <= addr_n;
            tmr_writedata  <= data_n;
            if (state == ST_IDLE && arb_found) begin
                owner    <= arb_idx;
                owner_oh <= arb_grant;
                delay    <= sel_ticks;
                ptr      <= (arb_idx == 3'(NUM_REQ-1)) ? 3'd0 : arb_idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_timer_share_sched.sv
// Bench for timer_share_sched: behavioural timer slave, a round-robin /
// programming-sequence reference model, and an expected-write scoreboard.
module tb_timer_share_sched;

    localparam int N = 4;
    localparam int W = 32;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req;
    logic [N*W-1:0]  req_ticks;
    logic [N-1:0]    done;
    logic            busy;
    logic [2:0]      owner;
    logic [2:0]      tmr_address;
    logic            tmr_chipselect;
    logic            tmr_write_n;
    logic [15:0]     tmr_writedata;
    logic            tmr_irq;
    logic [3:0]      state;

    int              n_checks = 0;
    int              n_fail   = 0;
    int              cyc      = 0;
    int              mptr     = 0;
    int              ticks_m[N];
    logic [N-1:0]    pend;
    logic [18:0]     exp_q[$];

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    timer_share_sched #(.NUM_REQ(N), .TICK_W(W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .req_ticks      (req_ticks),
        .done           (done),
        .busy           (busy),
        .owner          (owner),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_irq        (tmr_irq),
        .state          (state)
    );

    // Behavioural interval timer: one-shot countdown from period to 0,
    // registered irq, cleared by any status write.
    logic [31:0] tm_period;
    logic [31:0] tm_cnt;
    logic        tm_run;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmr_irq <= 1'b0; tm_run <= 1'b0; tm_cnt <= 0; tm_period <= 0;
        end else if (tmr_chipselect && !tmr_write_n) begin
            case (tmr_address)
                3'd0: tmr_irq <= 1'b0;
                3'd1: if (tmr_writedata[2]) begin tm_run <= 1'b1; tm_cnt <= tm_period; end
                      else if (tmr_writedata[3]) tm_run <= 1'b0;
                3'd2: begin tm_period[15:0]  <= tmr_writedata; tm_run <= 1'b0; end
                3'd3: begin tm_period[31:16] <= tmr_writedata; tm_run <= 1'b0; end
                default: ;
            endcase
        end else if (tm_run) begin
            if (tm_cnt == 0) begin tmr_irq <= 1'b1; tm_run <= 1'b0; end
            else tm_cnt <= tm_cnt - 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_wr(input logic [2:0] a, input logic [15:0] d);
        exp_q.push_back({a, d});
    endtask

    // Full programming sequence for a delay of eff ticks (already clamped).
    task automatic push_txn(input int eff);
        logic [31:0] per;
        per = 32'(eff - 1);
        push_wr(3'd1, 16'h0008);
        push_wr(3'd2, per[15:0]);
        push_wr(3'd3, per[31:16]);
        push_wr(3'd0, 16'h0000);
        push_wr(3'd1, 16'h0005);
        push_wr(3'd0, 16'h0000);
    endtask

    task automatic set_req(input logic [N-1:0] m);
        for (int i = 0; i < N; i++) req_ticks[i*W +: W] = 32'(ticks_m[i]);
        pend = m;
        req  = m;
    endtask

    // Advance to the next negedge and score any bus write seen there.
    task automatic step(output logic wr_seen);
        logic [18:0] e;
        @(negedge clk);
        if (tmr_chipselect) check("no_read", {31'b0, tmr_write_n}, 0);
        wr_seen = tmr_chipselect && !tmr_write_n;
        if (wr_seen) begin
            check("bus_expected", {31'b0, exp_q.size() != 0}, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("bus_write", {13'b0, tmr_address, tmr_writedata}, {13'b0, e});
            end
        end
    endtask

    task automatic abort_owner(input int w);
        req[w]  = 1'b0;
        pend[w] = 1'b0;
        exp_q.delete();
        push_wr(3'd1, 16'h0008);
        push_wr(3'd0, 16'h0000);
    endtask

    // Serve every pending request. cancel_at: 0 none, 1..5 drop req after
    // that programming write, 6 drop req while waiting for irq.
    task automatic serve(input int cancel_w, input int cancel_at);
        int w, eff, n, t0, last_end, lat, kk;
        logic wr, fin, canc;
        last_end = -1;
        while (pend != 0) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                int c = (mptr + k) % N;
                if (w < 0 && pend[c]) w = c;
            end
            mptr = (w + 1) % N;
            eff  = (ticks_m[w] < 2) ? 2 : ticks_m[w];
            push_txn(eff);
            canc = (w == cancel_w) && (cancel_at != 0);
            kk   = (cancel_at > 5) ? 5 : cancel_at;
            n = 0; t0 = 0; fin = 1'b0;
            for (int c = 0; c < eff + 60 && !fin; c++) begin
                step(wr);
                if (wr) begin
                    n++;
                    if (n == 1) begin
                        check("owner", 32'(owner), 32'(w));
                        check("busy_granted", {31'b0, busy}, 1);
                        if (last_end >= 0) check("idle_gap", 32'(cyc - last_end), 2);
                        // late changes to the owner's delay must not matter
                        req_ticks[w*W +: W] = $urandom;
                    end
                    if (n == 5) t0 = cyc;
                    if (canc && cancel_at <= 5 && n == cancel_at) abort_owner(w);
                    if (canc && n == kk + 2) begin fin = 1'b1; last_end = cyc; end
                end
                if (canc && cancel_at == 6 && n == 5 && cyc == t0 + 3) abort_owner(w);
                if (done != 0) begin
                    check("done", 32'(done), canc ? 0 : (32'd1 << w));
                    if (!canc) begin
                        lat = cyc - t0;
                        check("latency_window", {31'b0, (lat >= eff - 4) && (lat <= eff + 4)}, 1);
                        check("writes_per_txn", 32'(n), 6);
                        req[w] = 1'b0; pend[w] = 1'b0;
                        fin = 1'b1; last_end = cyc;
                    end
                end
            end
            check("txn_finished", {31'b0, fin}, 1);
            if (!fin) begin req[w] = 1'b0; pend[w] = 1'b0; exp_q.delete(); end
        end
        for (int i = 0; i < 3; i++) begin
            step(wr);
            check("done_idle", 32'(done), 0);
        end
        check("busy_idle", {31'b0, busy}, 0);
        check("exp_q_empty", 32'(exp_q.size()), 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"},  {31'b0, busy}, 0);
        check({tag, "_done"},  32'(done), 0);
        check({tag, "_owner"}, 32'(owner), 0);
        check({tag, "_cs"},    {31'b0, tmr_chipselect}, 0);
        check({tag, "_wn"},    {31'b0, tmr_write_n}, 1);
        check({tag, "_addr"},  32'(tmr_address), 0);
        check({tag, "_data"},  32'(tmr_writedata), 0);
    endtask

    initial begin
        logic wr;
        int   n, m, cw, ca;
        reset_n = 1'b0;
        req = '0;
        req_ticks = '0;
        pend = '0;
        for (int i = 0; i < N; i++) ticks_m[i] = 0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        reset_n = 1'b1;
        step(wr);

        // contention: all four at ticks=4, strict order 0,1,2,3 then 0 again
        for (int i = 0; i < N; i++) ticks_m[i] = 4;
        set_req(4'b1111);
        serve(-1, 0);
        set_req(4'b0001);
        serve(-1, 0);

        // single request
        ticks_m[0] = 10; set_req(4'b0001); serve(-1, 0);

        // clamp boundaries
        ticks_m[1] = 0; set_req(4'b0010); serve(-1, 0);
        ticks_m[1] = 1; set_req(4'b0010); serve(-1, 0);
        ticks_m[3] = 2; set_req(4'b1000); serve(-1, 0);

        // large delay: check 32-bit period split, then cancel during the wait
        ticks_m[2] = 32'h0001_86A0; set_req(4'b0100); serve(2, 6);

        // cancel after each programming write
        for (int k = 1; k <= 5; k++) begin
            cw = $urandom_range(0, N - 1);
            ticks_m[cw] = $urandom_range(2, 20);
            set_req(4'(1 << cw));
            serve(cw, k);
        end

        // randomized request mixes, some with a cancel
        for (int r = 0; r < 14; r++) begin
            m = $urandom_range(1, (1 << N) - 1);
            for (int i = 0; i < N; i++) ticks_m[i] = $urandom_range(0, 24);
            cw = -1; ca = 0;
            if ($urandom_range(0, 2) == 0) begin
                do cw = $urandom_range(0, N - 1); while (!m[cw]);
                ca = $urandom_range(1, 6);
                if (ca == 6 && ticks_m[cw] < 10) ca = $urandom_range(1, 5);
            end
            set_req(4'(m));
            serve(cw, ca);
        end

        // asynchronous reset while waiting for irq, then a fresh request
        ticks_m[1] = 200; set_req(4'b0010);
        mptr = 2;
        push_txn(200);
        n = 0;
        for (int c = 0; c < 20 && n < 5; c++) begin
            step(wr);
            if (wr) n++;
        end
        check("wait_reached", 32'(n), 5);
        repeat (3) step(wr);
        #2 reset_n = 1'b0;
        #1 check_reset("async_reset");
        @(negedge clk); @(negedge clk);
        check_reset("held_reset");
        req = '0; pend = '0; exp_q.delete(); mptr = 0;
        reset_n = 1'b1;
        step(wr);
        ticks_m[3] = 6; set_req(4'b1000); serve(-1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
